pi_req_queue: RTL and testbench
===============================

Name: pi_req_queue

Overview:
- Upstream stage of the 68k bus engine: decodes Pi register writes (PI_A / PI_WR / data pins) into complete bus requests.
- Buffers requests in a small FIFO so the Pi can post writes back-to-back.
- Presents the FIFO head to the bus state machine over a valid/ready handshake.
- Captures read data from the completion handshake and exposes busy/full/overflow status for the Pi status register.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
LW, 3, level width; must equal clog2(DEPTH)+1

Ports:
sys_clk  in  1  system clock (PLL output)
nRST  in  1  asynchronous active-low reset
pi_wr  in  1  raw PI_WR from GPIO, asynchronous; write strobe on falling edge
pi_a  in  3  Pi register address, stable around the strobe
pi_din  in  16  Pi data bus, stable around the strobe
req_valid  out  1  FIFO head valid
req_ready  in  1  bus engine accepts head
req_fc  out  3  head function code
req_read  out  1  head is a read
req_size  out  2  head size (bit1 = 32-bit split transfer)
req_addr  out  24  head address
req_wdata  out  32  head write data
cmp_valid  in  1  one-cycle pulse: bus engine finished in-flight request
cmp_rdata  in  32  read data, valid with cmp_valid
rd_data  out  32  last completed read data
busy  out  1  FIFO non-empty or request in flight (drives GPIO3)
full  out  1  level == DEPTH
overflow  out  1  sticky: a request was dropped
level  out  LW  FIFO occupancy

Behaviour:
- Reset (async, nRST=0): FIFO empty; staging regs, rd_data, in_flight, overflow cleared; all outputs 0. Sync flops reset to 1 (PI_WR idle high).
- Strobe detect: two-flop synchronizer s0→s1, plus delay flop s2. Strobe = s2 & ~s1. One pulse per falling edge; 3-cycle latency from the pin edge. pi_a/pi_din are sampled in the strobe cycle.
- Decode on strobe:
  - DATA_LO(0): stage wdata[15:0]
  - DATA_HI(1): stage wdata[31:16]
  - ADDR_LO(2): stage addr[15:0]
  - ADDR_HI(3): push {pi_din[13:11] fc, pi_din[10] read, pi_din[9:8] size, pi_din[7:0]+addr[15:0], wdata}
  - CONTROL(4): bit0 = clear overflow; bit1 = flush FIFO
  - Other addresses: ignored
- Staging registers persist after a push, so a repeated write needs only ADDR_HI.
- Push acceptance: accepted if level<DEPTH, or if a pop occurs in the same cycle. Otherwise the request is dropped, overflow is set, and the FIFO is unchanged.
- FIFO: first-word-fall-through. req_* reflect the head combinationally from storage; req_valid = level!=0. Pop when req_valid & req_ready. Simultaneous push and pop leaves level unchanged. Pointers wrap modulo DEPTH.
- Head fields are don't-care while req_valid=0; the bench checks them only when valid.
- In-flight tracking:
  - Pop sets in_flight=1 and in_flight_read=req_read.
  - cmp_valid clears in_flight. If in_flight_read=1, rd_data <= cmp_rdata in the same edge (visible the next cycle).
  - cmp_valid with in_flight=0 is ignored.
  - A pop and a cmp_valid in the same cycle are legal: the completion retires the old request and the pop starts the new one (in_flight stays 1).
- busy = (level!=0) | in_flight. The Pi polls busy=0 before reading rd_data.
- Flush: empties the FIFO only; the in-flight request still completes. A flush in the same cycle as a push discards the push and does not set overflow.
- Overflow: clear-on-control-bit0. If clear and a new drop happen in the same cycle, set wins.

Decomposition:
- Shared global header holds:
  - PI_REG_* address constants (DATA_LO=0, DATA_HI=1, ADDR_LO=2, ADDR_HI=3, CONTROL/STATUS=4, VERSION=7)
  - ADDR_HI field positions
  - CONTROL bit positions
  - request entry width (62 bits)
- One sub-module: sync_fifo (DEPTH, WIDTH; push/pop/flush/level, FWFT). Decode, strobe detect and in-flight tracking stay in pi_req_queue.

Test Plan:
- Single write: DATA_LO=0xBEEF, DATA_HI=0xDEAD, ADDR_LO=0x1234, ADDR_HI=0x1A56 (fc=3, write, size=2), req_ready=1 → req_valid for one cycle with addr=0x561234, wdata=0xDEADBEEF, fc=3, size=2, read=0; busy stays high until cmp_valid.
- Read completion: ADDR_HI with bit10=1, bench answers cmp_valid with cmp_rdata=0xCAFEF00D → rd_data=0xCAFEF00D one cycle later, busy falls the same cycle.
- Posting: req_ready=0, push 4 requests → level=4, full=1. A 5th push → dropped, overflow=1, level=4. Raise req_ready → heads pop in order, with addresses matching push order.
- Full plus simultaneous pop: level=4, strobe an ADDR_HI in the same cycle as a pop → level stays 4, overflow stays 0, new entry is last out.
- Control: write CONTROL=0x0003 with 2 entries queued and one in flight → level=0, overflow=0, busy stays 1 until cmp_valid, then 0.
- Reset mid-operation: assert nRST with level=3 and in_flight=1 → all outputs 0 immediately (async). After release, no spurious strobe while pi_wr stays high.

Source files
------------

// File: rtl/pi_req_queue_pkg.sv
// Shared definitions for the Pi request queue: register map, ADDR_HI/CONTROL
// field positions and the packed request entry carried through the FIFO.
package pi_req_queue_pkg;

    localparam logic [2:0] PiRegDataLo  = 3'd0;
    localparam logic [2:0] PiRegDataHi  = 3'd1;
    localparam logic [2:0] PiRegAddrLo  = 3'd2;
    localparam logic [2:0] PiRegAddrHi  = 3'd3;
    localparam logic [2:0] PiRegControl = 3'd4;
    localparam logic [2:0] PiRegStatus  = 3'd4;
    localparam logic [2:0] PiRegVersion = 3'd7;

    localparam int unsigned AddrHiFcMsb   = 13;
    localparam int unsigned AddrHiFcLsb   = 11;
    localparam int unsigned AddrHiRead    = 10;
    localparam int unsigned AddrHiSizeMsb = 9;
    localparam int unsigned AddrHiSizeLsb = 8;
    localparam int unsigned AddrHiAddrMsb = 7;

    localparam int unsigned CtrlClrOvf = 0;
    localparam int unsigned CtrlFlush  = 1;

    localparam int unsigned ReqEntryW = 62;

    typedef struct packed {
        logic [2:0]  fc;
        logic        read;
        logic [1:0]  size;
        logic [23:0] addr;
        logic [31:0] wdata;
    } req_entry_t;

endpackage

// File: rtl/pi_req_queue_if.sv
// Request/completion handshake between the Pi request queue (master) and the
// 68k bus state machine (slave).
interface pi_req_queue_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_fc;
    logic        req_read;
    logic [1:0]  req_size;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        cmp_valid;
    logic [31:0] cmp_rdata;

    modport master (
        output req_valid, req_fc, req_read, req_size, req_addr, req_wdata,
        input  req_ready, cmp_valid, cmp_rdata
    );

    modport slave (
        input  req_valid, req_fc, req_read, req_size, req_addr, req_wdata,
        output req_ready, cmp_valid, cmp_rdata
    );

endinterface

// File: rtl/pi_req_queue_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; a push into a full FIFO
// is accepted only when a pop frees the slot in the same cycle.
module pi_req_queue_sync_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 62,
    parameter int unsigned LvlW  = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [Width-1:0] rdata_o,
    output logic [LvlW-1:0]  level_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             empty, full, do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LvlW'(Depth));
    assign do_pop  = pop_i & ~empty;
    // Flush discards a coincident push outright, so it never counts as a drop.
    assign do_push = push_i & ~flush_i & (~full | do_pop);
    assign drop_o  = push_i & ~flush_i & full & ~do_pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AddrW'(1);
            if (do_pop)  rptr_d = rptr_q + AddrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + LvlW'(1);
                2'b01:   level_d = level_q - LvlW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            if (do_push) mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;
    assign full_o  = full;

endmodule

// File: rtl/pi_req_queue.sv
// Decodes Pi register writes into 68k bus requests, queues them, and tracks the
// in-flight request and its read data for the Pi status register.
module pi_req_queue
    import pi_req_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LW    = 3
) (
    input  logic                 sys_clk,
    input  logic                 nRST,
    input  logic                 pi_wr_i,
    input  logic [2:0]           pi_a_i,
    input  logic [15:0]          pi_din_i,
    pi_req_queue_if.master       bus_if,
    output logic [31:0]          rd_data_o,
    output logic                 busy_o,
    output logic                 full_o,
    output logic                 overflow_o,
    output logic [LW-1:0]        level_o
);

    logic        s0_q, s1_q, s2_q;
    logic        strobe;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] addr_lo_q, addr_lo_d;
    logic        push, flush, clr_ovf, drop, pop;
    req_entry_t  push_entry, head;
    logic        in_flight_q, in_flight_d;
    logic        in_flight_read_q, in_flight_read_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        overflow_q, overflow_d;
    logic [LW-1:0] level;

    // PI_WR idles high, so the synchronizer resets high to avoid a false strobe.
    always_ff @(posedge sys_clk or negedge nRST) begin
        if (!nRST) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s0_q <= pi_wr_i;
            s1_q <= s0_q;
            s2_q <= s1_q;
        end
    end

    assign strobe = s2_q & ~s1_q;

    always_comb begin
        push_entry.fc    = pi_din_i[AddrHiFcMsb:AddrHiFcLsb];
        push_entry.read  = pi_din_i[AddrHiRead];
        push_entry.size  = pi_din_i[AddrHiSizeMsb:AddrHiSizeLsb];
        push_entry.addr  = {pi_din_i[AddrHiAddrMsb:0], addr_lo_q};
        push_entry.wdata = wdata_q;
    end

    always_comb begin
        wdata_d   = wdata_q;
        addr_lo_d = addr_lo_q;
        push      = 1'b0;
        flush     = 1'b0;
        clr_ovf   = 1'b0;
        if (strobe) begin
            case (pi_a_i)
                PiRegDataLo:  wdata_d[15:0]  = pi_din_i;
                PiRegDataHi:  wdata_d[31:16] = pi_din_i;
                PiRegAddrLo:  addr_lo_d      = pi_din_i;
                PiRegAddrHi:  push           = 1'b1;
                PiRegControl: begin
                    clr_ovf = pi_din_i[CtrlClrOvf];
                    flush   = pi_din_i[CtrlFlush];
                end
                default: ;
            endcase
        end
    end

    pi_req_queue_sync_fifo #(
        .Depth (DEPTH),
        .Width ($bits(req_entry_t)),
        .LvlW  (LW)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (nRST),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (head),
        .level_o (level),
        .full_o  (full_o),
        .drop_o  (drop)
    );

    assign bus_if.req_valid = (level != '0);
    assign bus_if.req_fc    = head.fc;
    assign bus_if.req_read  = head.read;
    assign bus_if.req_size  = head.size;
    assign bus_if.req_addr  = head.addr;
    assign bus_if.req_wdata = head.wdata;

    assign pop = bus_if.req_valid & bus_if.req_ready;

    // A pop in the same cycle as a completion retires the old request and
    // starts the new one, so pop takes priority for in_flight.
    always_comb begin
        in_flight_d      = in_flight_q;
        in_flight_read_d = in_flight_read_q;
        rd_data_d        = rd_data_q;
        if (bus_if.cmp_valid && in_flight_q) begin
            in_flight_d = 1'b0;
            if (in_flight_read_q) rd_data_d = bus_if.cmp_rdata;
        end
        if (pop) begin
            in_flight_d      = 1'b1;
            in_flight_read_d = head.read;
        end
        overflow_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
    end

    always_ff @(posedge sys_clk or negedge nRST) begin
        if (!nRST) begin
            wdata_q          <= '0;
            addr_lo_q        <= '0;
            in_flight_q      <= 1'b0;
            in_flight_read_q <= 1'b0;
            rd_data_q        <= '0;
            overflow_q       <= 1'b0;
        end else begin
            wdata_q          <= wdata_d;
            addr_lo_q        <= addr_lo_d;
            in_flight_q      <= in_flight_d;
            in_flight_read_q <= in_flight_read_d;
            rd_data_q        <= rd_data_d;
            overflow_q       <= overflow_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign busy_o     = (level != '0) | in_flight_q;
    assign overflow_o = overflow_q;
    assign level_o    = level;

endmodule

// File: tb/tb_pi_req_queue.sv
// Directed self-checking bench for pi_req_queue: Pi writes, FIFO posting,
// completions, control register and asynchronous reset.
module tb_pi_req_queue;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        pi_wr = 1'b1;
    logic [2:0]  pi_a = 3'd0;
    logic [15:0] pi_din = 16'd0;
    logic [31:0] rd_data;
    logic        busy, full, overflow;
    logic [2:0]  level;
    int          checks = 0;
    int          failures = 0;

    pi_req_queue_if bus_if ();

    pi_req_queue #(
        .DEPTH (4),
        .LW    (3)
    ) dut (
        .sys_clk    (clk),
        .nRST       (nrst),
        .pi_wr_i    (pi_wr),
        .pi_a_i     (pi_a),
        .pi_din_i   (pi_din),
        .bus_if     (bus_if),
        .rd_data_o  (rd_data),
        .busy_o     (busy),
        .full_o     (full),
        .overflow_o (overflow),
        .level_o    (level)
    );

    always #5 clk = ~clk;

    task automatic pi_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        pi_a = a; pi_din = d; pi_wr = 1'b0;
        repeat (4) @(negedge clk);
        pi_wr = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk); bus_if.req_ready = 1'b1;
        @(negedge clk); bus_if.req_ready = 1'b0;
    endtask

    task automatic complete(input logic [31:0] rdata);
        @(negedge clk); bus_if.cmp_valid = 1'b1; bus_if.cmp_rdata = rdata;
        @(negedge clk); bus_if.cmp_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (level !== 3'd0 || busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
            failures++; $display("FAIL reset_status got lvl=%0d busy=%b full=%b ovf=%b exp 0", level, busy, full, overflow); end
        checks++; if (bus_if.req_valid !== 1'b0 || rd_data !== 32'd0) begin
            failures++; $display("FAIL reset_out got valid=%b rd=%h exp 0", bus_if.req_valid, rd_data); end
        @(negedge clk); nrst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (level !== 3'd0 || bus_if.req_valid !== 1'b0) begin
            failures++; $display("FAIL reset_nostrobe got lvl=%0d valid=%b exp 0", level, bus_if.req_valid); end
    endtask

    task automatic test_single_write();
        pi_write(3'd0, 16'hBEEF);
        pi_write(3'd1, 16'hDEAD);
        pi_write(3'd2, 16'h1234);
        pi_write(3'd3, 16'h1A56);
        checks++; if (bus_if.req_valid !== 1'b1 || level !== 3'd1 || busy !== 1'b1) begin
            failures++; $display("FAIL sw_valid got valid=%b lvl=%0d busy=%b exp 1/1/1", bus_if.req_valid, level, busy); end
        checks++; if (bus_if.req_addr !== 24'h561234 || bus_if.req_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL sw_head got addr=%h wdata=%h exp 561234/deadbeef", bus_if.req_addr, bus_if.req_wdata); end
        checks++; if (bus_if.req_fc !== 3'd3 || bus_if.req_size !== 2'd2 || bus_if.req_read !== 1'b0) begin
            failures++; $display("FAIL sw_fields got fc=%0d size=%0d rd=%b exp 3/2/0", bus_if.req_fc, bus_if.req_size, bus_if.req_read); end
        pop_one();
        checks++; if (bus_if.req_valid !== 1'b0 || level !== 3'd0 || busy !== 1'b1) begin
            failures++; $display("FAIL sw_inflight got valid=%b lvl=%0d busy=%b exp 0/0/1", bus_if.req_valid, level, busy); end
        complete(32'h0BADBEEF);
        checks++; if (busy !== 1'b0 || rd_data !== 32'd0) begin
            failures++; $display("FAIL sw_done got busy=%b rd=%h exp 0/0", busy, rd_data); end
    endtask

    task automatic test_read();
        pi_write(3'd3, 16'h1E56);
        checks++; if (bus_if.req_valid !== 1'b1 || bus_if.req_read !== 1'b1 || bus_if.req_addr !== 24'h561234) begin
            failures++; $display("FAIL rd_head got valid=%b rd=%b addr=%h exp 1/1/561234", bus_if.req_valid, bus_if.req_read, bus_if.req_addr); end
        pop_one();
        complete(32'hCAFEF00D);
        checks++; if (rd_data !== 32'hCAFEF00D || busy !== 1'b0) begin
            failures++; $display("FAIL rd_data got rd=%h busy=%b exp cafef00d/0", rd_data, busy); end
        complete(32'h11111111);
        checks++; if (rd_data !== 32'hCAFEF00D || busy !== 1'b0) begin
            failures++; $display("FAIL rd_stray_cmp got rd=%h busy=%b exp cafef00d/0", rd_data, busy); end
    endtask

    task automatic test_posting();
        for (int k = 1; k <= 4; k++) pi_write(3'd3, 16'h1A00 | 16'(k));
        checks++; if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
            failures++; $display("FAIL post_full got lvl=%0d full=%b ovf=%b exp 4/1/0", level, full, overflow); end
        pi_write(3'd3, 16'h1A05);
        checks++; if (level !== 3'd4 || overflow !== 1'b1) begin
            failures++; $display("FAIL post_drop got lvl=%0d ovf=%b exp 4/1", level, overflow); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (bus_if.req_addr !== {8'(k), 16'h1234} || bus_if.req_wdata !== 32'hDEADBEEF) begin
                failures++; $display("FAIL post_order%0d got addr=%h wdata=%h exp %h/deadbeef", k, bus_if.req_addr, bus_if.req_wdata, {8'(k), 16'h1234}); end
            pop_one();
        end
        checks++; if (level !== 3'd0 || full !== 1'b0 || bus_if.req_valid !== 1'b0) begin
            failures++; $display("FAIL post_empty got lvl=%0d full=%b valid=%b exp 0/0/0", level, full, bus_if.req_valid); end
        complete(32'h0);
        pi_write(3'd4, 16'h0001);
        checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL post_clr got ovf=%b busy=%b exp 0/0", overflow, busy); end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_hi [4];
        exp_hi[0] = 8'd2; exp_hi[1] = 8'd3; exp_hi[2] = 8'd4; exp_hi[3] = 8'd9;
        for (int k = 1; k <= 4; k++) pi_write(3'd3, 16'h1A00 | 16'(k));
        // Pulse ready exactly in the strobe cycle so push and pop share an edge.
        @(negedge clk); pi_a = 3'd3; pi_din = 16'h1A09; pi_wr = 1'b0;
        @(negedge clk);
        @(negedge clk); bus_if.req_ready = 1'b1;
        @(negedge clk); bus_if.req_ready = 1'b0;
        checks++; if (level !== 3'd4 || overflow !== 1'b0) begin
            failures++; $display("FAIL fp_level got lvl=%0d ovf=%b exp 4/0", level, overflow); end
        pi_wr = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus_if.req_addr !== {exp_hi[i], 16'h1234}) begin
                failures++; $display("FAIL fp_order%0d got addr=%h exp %h", i, bus_if.req_addr, {exp_hi[i], 16'h1234}); end
            pop_one();
        end
        complete(32'h0);
        checks++; if (busy !== 1'b0 || level !== 3'd0) begin
            failures++; $display("FAIL fp_done got busy=%b lvl=%0d exp 0/0", busy, level); end
    endtask

    task automatic test_control();
        for (int k = 1; k <= 5; k++) pi_write(3'd3, 16'h1A00 | 16'(k));
        pop_one();
        pop_one();
        checks++; if (level !== 3'd2 || overflow !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL ctl_pre got lvl=%0d ovf=%b busy=%b exp 2/1/1", level, overflow, busy); end
        pi_write(3'd4, 16'h0003);
        checks++; if (level !== 3'd0 || overflow !== 1'b0 || bus_if.req_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL ctl_flush got lvl=%0d ovf=%b valid=%b busy=%b exp 0/0/0/1", level, overflow, bus_if.req_valid, busy); end
        complete(32'h0);
        checks++; if (busy !== 1'b0) begin
            failures++; $display("FAIL ctl_done got busy=%b exp 0", busy); end
    endtask

    task automatic test_ignored();
        pi_write(3'd5, 16'hFFFF);
        pi_write(3'd7, 16'hFFFF);
        checks++; if (level !== 3'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL ign_status got lvl=%0d ovf=%b busy=%b exp 0/0/0", level, overflow, busy); end
        pi_write(3'd3, 16'h1A33);
        checks++; if (bus_if.req_addr !== 24'h331234 || bus_if.req_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL ign_staging got addr=%h wdata=%h exp 331234/deadbeef", bus_if.req_addr, bus_if.req_wdata); end
        pop_one();
        complete(32'h0);
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 5; k++) pi_write(3'd3, 16'h1A00 | 16'(k));
        pop_one();
        checks++; if (level !== 3'd3 || busy !== 1'b1 || overflow !== 1'b1) begin
            failures++; $display("FAIL rm_pre got lvl=%0d busy=%b ovf=%b exp 3/1/1", level, busy, overflow); end
        #2 nrst = 1'b0;
        #1;
        checks++; if (level !== 3'd0 || busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
            failures++; $display("FAIL rm_status got lvl=%0d busy=%b full=%b ovf=%b exp 0", level, busy, full, overflow); end
        checks++; if (rd_data !== 32'd0 || bus_if.req_valid !== 1'b0 || bus_if.req_addr !== 24'd0) begin
            failures++; $display("FAIL rm_out got rd=%h valid=%b addr=%h exp 0", rd_data, bus_if.req_valid, bus_if.req_addr); end
        @(negedge clk); nrst = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (level !== 3'd0 || bus_if.req_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rm_after got lvl=%0d valid=%b busy=%b exp 0", level, bus_if.req_valid, busy); end
    endtask

    initial begin
        bus_if.req_ready = 1'b0;
        bus_if.cmp_valid = 1'b0;
        bus_if.cmp_rdata = 32'd0;
        test_reset();
        test_single_write();
        test_read();
        test_posting();
        test_full_pop();
        test_control();
        test_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
